joy_adc_scheduler: RTL and testbench
====================================

Name: joy_adc_scheduler

Overview:
- Sequences the shared 12-bit joystick ADC: round-robins conversions across NUM_CH analog channels over a start/done handshake.
- Stores the latest sample per channel.
- Converts each channel into debounced up/down step pulses with hold delay and auto-repeat.
- Sits between the ADC interface and consumers such as the colour and position selectors. Those consumers see single-cycle steps only, with no raw threshold logic.

Parameters:
- NUM_CH, 2, number of ADC channels scanned (1..4); channel index width is 2.
- HI_THRESH, 12'h750, a sample strictly above this value is "up".
- LO_THRESH, 12'h500, a sample strictly below this value is "down".
- SETTLE_CYCLES, 16, idle cycles after changing adc_chan before adc_start.
- HOLD_CYCLES, 5000000, cycles from the first step to the first auto-repeat.
- REPEAT_CYCLES, 2500000, cycles between subsequent auto-repeats.
- TIMEOUT_CYCLES, 1024, maximum wait for adc_done (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; when low, the current conversion finishes and the FSM then parks in IDLE
- adc_chan  out  2  channel select to the ADC mux
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle pulse: adc_data is valid this cycle
- adc_data  in  12  conversion result
- sample_valid  out  1  one-cycle pulse when a sample is stored
- sample_chan  out  2  channel of the stored sample
- sample_data  out  12  stored sample value
- step_up  out  NUM_CH  per-channel one-cycle up-step pulse
- step_dn  out  NUM_CH  per-channel one-cycle down-step pulse
- adc_err  out  1  sticky conversion-timeout flag (optional feature)

Behaviour:
- Reset state (asynchronous, reset_n low):
  - FSM in IDLE; adc_chan=0; adc_start=0.
  - sample_valid=0; sample_chan=0; sample_data=0.
  - step_up=0; step_dn=0; adc_err=0.
  - All per-channel direction states NEUTRAL; all counters 0.
- Scan FSM states: IDLE, SETTLE, START, WAIT, STORE.
  - IDLE: if enable, go to SETTLE with the settle counter cleared.
  - SETTLE: count up; after SETTLE_CYCLES cycles, go to START.
  - START: adc_start=1 for exactly one cycle; go to WAIT.
  - WAIT: hold until adc_done.
    - On adc_done: latch adc_data into sample_data and adc_chan into sample_chan; go to STORE.
    - adc_done in any other state is ignored.
  - STORE: sample_valid=1 for one cycle; run the direction update for the channel.
    - adc_chan advances to (adc_chan+1) when below NUM_CH-1, else wraps to 0.
    - Go to SETTLE if enable, else IDLE.
- Latency: adc_done to sample_valid is exactly 1 cycle. Minimum scan period per channel is SETTLE_CYCLES+3+ADC conversion time.
- Per-channel direction machine: states NEUTRAL, HELD_UP, HELD_DN.
  - The repeat counter (width $clog2(max(HOLD,REPEAT))+1) increments every clk while HELD_*, saturating at its maximum.
  - Classification of a stored sample s: up if s>HI_THRESH; down if s<LO_THRESH; else neutral. Boundary values 12'h750 and 12'h500 are neutral.
  - NEUTRAL and up: step_up pulse in the STORE cycle; go to HELD_UP; counter=0; first_repeat=1. Down is symmetric with step_dn and HELD_DN.
  - HELD_UP and up: if counter >= (first_repeat ? HOLD_CYCLES : REPEAT_CYCLES), pulse step_up, counter=0, first_repeat=0; otherwise no pulse. Repeats are evaluated only at STORE cycles, so repeat granularity is one scan period.
  - HELD_UP and down: immediate step_dn; go to HELD_DN; counter=0; first_repeat=1. HELD_DN and up is the mirror case.
  - Any HELD state and neutral: go to NEUTRAL, no pulse.
- Step pulses are never asserted outside a STORE cycle. Only the stored channel's bit can be set. step_up and step_dn are never both high for the same channel.
- enable deassertion does not clear direction states. Held channels resume their counter comparison on the next sample.
- reset_n assertion mid-conversion aborts immediately. A late adc_done after reset release, while in IDLE or SETTLE, is ignored.

Optional Feature:
- Macro JOY_ADC_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles; if TIMEOUT_CYCLES elapse without adc_done, set adc_err=1 (sticky until reset).
  - No sample is stored, no sample_valid, and direction state is unchanged.
  - adc_chan advances as in STORE; go to SETTLE or IDLE.
- Undefined: WAIT blocks indefinitely; adc_err is tied 0.

Test Plan:
All scenarios use NUM_CH=2, SETTLE=4, HOLD=40, REPEAT=20, TIMEOUT=32, with an ADC model that answers 10 cycles after adc_start.
- Reset then enable=1, ch0=12'h600, ch1=12'h600 -> adc_start pulses alternate adc_chan 0,1,0; sample_valid 1 cycle after each adc_done; no steps.
- ch0=12'h800 held -> step_up[0] at the first ch0 STORE; the next pulse comes at the first ch0 STORE with counter>=40, then every ch0 STORE with counter>=20; step_dn stays 0.
- ch0 boundary values 12'h750 and 12'h500 -> no step pulses; 12'h751 -> step_up[0]; 12'h4FF -> step_dn[0].
- ch1 moves 12'h800 to 12'h100 in consecutive samples -> step_up[1] then step_dn[1] immediately, with no neutral sample between.
- enable dropped during WAIT -> conversion completes, sample_valid fires, FSM idles; re-enable resumes at the next channel.
- Macro defined, ADC model never answers -> adc_err=1 after 32 WAIT cycles, adc_chan advances, no sample_valid; reset_n low clears adc_err asynchronously.

Source files
------------

// File: rtl/joy_adc_scheduler.sv
// Joystick ADC scan sequencer: round-robin conversions, per-channel sample store and debounced
// step pulses with hold/auto-repeat. Optional conversion timeout enabled by JOY_ADC_TIMEOUT_EN.
module joy_adc_scheduler #(
    parameter int          NUM_CH         = 2,
    parameter logic [11:0] HI_THRESH      = 12'h750,
    parameter logic [11:0] LO_THRESH      = 12'h500,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          HOLD_CYCLES    = 5000000,
    parameter int          REPEAT_CYCLES  = 2500000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        adc_chan,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [11:0]       adc_data,
    output logic              sample_valid,
    output logic [1:0]        sample_chan,
    output logic [11:0]       sample_data,
    output logic [NUM_CH-1:0] step_up,
    output logic [NUM_CH-1:0] step_dn,
    output logic              adc_err,
    output logic [2:0]        dbg_state
);
    // Handshake: adc_start is a one-cycle request while adc_chan is stable; adc_done is a
    // one-cycle pulse qualifying adc_data and is only accepted in WAIT.
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_STORE} scan_state_e;
    typedef enum logic [1:0] {D_NEUTRAL, D_HELD_UP, D_HELD_DN} dir_e;

    localparam int MAXR = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(MAXR) + 1;
    localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_R      = RW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REPEAT_R    = RW'(REPEAT_CYCLES);

    scan_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              chan_adv, latch;
    dir_e              dir_q [NUM_CH];
    dir_e              dir_d [NUM_CH];
    logic [RW-1:0]     rep_q [NUM_CH];
    logic [RW-1:0]     rep_d [NUM_CH];
    logic [NUM_CH-1:0] first_q, first_d;
    logic              is_up, is_dn;

    assign dbg_state    = state_q;
    assign adc_start    = (state_q == S_START);
    assign sample_valid = (state_q == S_STORE);
    assign is_up        = (sample_data > HI_THRESH);
    assign is_dn        = (sample_data < LO_THRESH);

`ifdef JOY_ADC_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic timeout, err_q;
    assign adc_err = err_q;
`else
    assign adc_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chan_adv = 1'b0;
        latch    = 1'b0;
`ifdef JOY_ADC_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (enable) begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: if (cnt_q == SETTLE_LAST) begin
                state_d = S_START;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: if (adc_done) begin
                latch   = 1'b1;
                state_d = S_STORE;
            end
`ifdef JOY_ADC_TIMEOUT_EN
            // A missing answer skips this channel without touching its stored sample.
            else if (cnt_q == TIMEOUT_LAST) begin
                timeout  = 1'b1;
                chan_adv = 1'b1;
                cnt_d    = '0;
                state_d  = enable ? S_SETTLE : S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            S_STORE: begin
                chan_adv = 1'b1;
                cnt_d    = '0;
                state_d  = enable ? S_SETTLE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Held counters run every cycle; the step decision is only taken for the stored channel.
    always_comb begin
        step_up = '0;
        step_dn = '0;
        first_d = first_q;
        for (int i = 0; i < NUM_CH; i++) begin
            dir_d[i] = dir_q[i];
            rep_d[i] = (dir_q[i] != D_NEUTRAL && rep_q[i] != {RW{1'b1}}) ? rep_q[i] + 1'b1 : rep_q[i];
            if (state_q == S_STORE && sample_chan == 2'(i)) begin
                if (!is_up && !is_dn) begin
                    dir_d[i] = D_NEUTRAL;
                    rep_d[i] = '0;
                end else if ((is_up && dir_q[i] == D_HELD_UP) || (is_dn && dir_q[i] == D_HELD_DN)) begin
                    if (rep_q[i] >= (first_q[i] ? HOLD_R : REPEAT_R)) begin
                        step_up[i] = is_up;
                        step_dn[i] = is_dn;
                        rep_d[i]   = '0;
                        first_d[i] = 1'b0;
                    end
                end else begin
                    step_up[i] = is_up;
                    step_dn[i] = is_dn;
                    dir_d[i]   = is_up ? D_HELD_UP : D_HELD_DN;
                    rep_d[i]   = '0;
                    first_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            adc_chan    <= '0;
            sample_chan <= '0;
            sample_data <= '0;
            first_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dir_q[i] <= D_NEUTRAL;
                rep_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            for (int i = 0; i < NUM_CH; i++) begin
                dir_q[i] <= dir_d[i];
                rep_q[i] <= rep_d[i];
            end
            if (latch) begin
                sample_chan <= adc_chan;
                sample_data <= adc_data;
            end
            if (chan_adv)
                adc_chan <= (adc_chan == 2'(NUM_CH - 1)) ? 2'd0 : adc_chan + 2'd1;
        end
    end

`ifdef JOY_ADC_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_joy_adc_scheduler.sv
// Randomized bench for joy_adc_scheduler: ADC responder, sample scoreboard and a
// cycle-stamped behavioural model of the step/hold/repeat rules.
module tb_joy_adc_scheduler;
  localparam int NUM_CH = 2, SETTLE = 4, HOLD = 40, REPEAT = 20, TIMEOUT = 32, ADC_LAT = 10;

  logic              clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [1:0]        adc_chan, sample_chan;
  logic              adc_start, adc_done, sample_valid, adc_err;
  logic [11:0]       adc_data, sample_data;
  logic [NUM_CH-1:0] step_up, step_dn;
  logic [2:0]        dbg_state;

  joy_adc_scheduler #(.NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD),
                      .REPEAT_CYCLES(REPEAT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_chan(adc_chan), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .sample_valid(sample_valid),
    .sample_chan(sample_chan), .sample_data(sample_data), .step_up(step_up),
    .step_dn(step_dn), .adc_err(adc_err), .dbg_state(dbg_state));

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  logic [13:0] exp_q[$];
  logic [11:0] chval [NUM_CH];
  bit   respond_en = 1'b1;
  int   m_dir [NUM_CH];
  int   m_last [NUM_CH];
  bit   m_first [NUM_CH];
  int   m_next_chan = 0;
  int   stores_seen [NUM_CH];
  int   ups [NUM_CH];
  int   dns [NUM_CH];
  int   n_starts = 0, n_valids = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_dir[i] = 0; m_last[i] = 0; m_first[i] = 1'b0;
    end
    m_next_chan = 0;
    exp_q.delete();
  endtask

  // Direction rules: 1 = held up, 2 = held down; elapsed counts cycles after the last pulse.
  task automatic model_store(input int ch, input logic [11:0] s, input int c,
                             output logic [NUM_CH-1:0] eu, output logic [NUM_CH-1:0] ed);
    int cls;
    bit pulse;
    cls = (s > 12'h750) ? 1 : ((s < 12'h500) ? 2 : 0);
    eu = '0; ed = '0; pulse = 1'b0;
    if (cls == 0) m_dir[ch] = 0;
    else if (m_dir[ch] == cls) begin
      if (c - m_last[ch] - 1 >= (m_first[ch] ? HOLD : REPEAT)) begin
        pulse = 1'b1; m_last[ch] = c; m_first[ch] = 1'b0;
      end
    end else begin
      pulse = 1'b1; m_dir[ch] = cls; m_last[ch] = c; m_first[ch] = 1'b1;
    end
    if (pulse && cls == 1) eu[ch] = 1'b1;
    if (pulse && cls == 2) ed[ch] = 1'b1;
  endtask

  // ADC responder: answers ADC_LAT cycles after each accepted start
  initial begin
    int ch;
    adc_done = 1'b0; adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_start && respond_en && reset_n) begin
        ch = int'(adc_chan);
        repeat (ADC_LAT) @(posedge clk);
        #1;
        adc_done = 1'b1; adc_data = chval[ch];
        exp_q.push_back({2'(ch), chval[ch]});
        @(posedge clk);
        #1 adc_done = 1'b0;
      end
    end
  end

  // scoreboard / monitor
  initial begin
    logic done_prev;
    logic [13:0] e;
    logic [NUM_CH-1:0] eu, ed;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) done_prev = 1'b0;
      else begin
        if (adc_start) begin
          chk("start_chan", 32'(adc_chan), 32'(m_next_chan));
          n_starts++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (step_up[i]) ups[i]++;
          if (step_dn[i]) dns[i]++;
        end
        if (sample_valid) begin
          n_valids++;
          chk("valid_latency", 32'(done_prev), 32'd1);
          if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("sample_chan", 32'(sample_chan), 32'(e[13:12]));
            chk("sample_data", 32'(sample_data), 32'(e[11:0]));
            model_store(int'(e[13:12]), e[11:0], cyc, eu, ed);
            chk("step_up", 32'(step_up), 32'(eu));
            chk("step_dn", 32'(step_dn), 32'(ed));
            m_next_chan = (int'(e[13:12]) + 1) % NUM_CH;
            stores_seen[int'(e[13:12])]++;
          end
        end else begin
          if (done_prev) chk("missing_valid", 32'd0, 32'd1);
          if (step_up != '0 || step_dn != '0) chk("stray_step", 32'({step_up, step_dn}), 32'd0);
        end
        done_prev = adc_done;
      end
    end
  end

  // driver tasks
  task automatic wait_stores(input int ch, input int n);
    int target, budget;
    target = stores_seen[ch] + n;
    budget = 40 * n + 100;
    while (stores_seen[ch] < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (stores_seen[ch] < target) chk("wait_stores_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start();
    int budget;
    budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (!adc_start && budget > 0);
    if (!adc_start) chk("wait_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_adc_chan", 32'(adc_chan), 32'd0);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_chan", 32'(sample_chan), 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    chk("rst_steps", 32'({step_up, step_dn}), 32'd0);
    chk("rst_adc_err", 32'(adc_err), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic set_and_check(input int ch, input logic [11:0] v, input int exp_up, input int exp_dn, input string tag);
    int u0, d0;
    wait_stores(ch, 1);
    chval[ch] = v;
    u0 = ups[ch]; d0 = dns[ch];
    wait_stores(ch, 1);
    chk({tag, "_up"}, 32'(ups[ch] - u0), 32'(exp_up));
    chk({tag, "_dn"}, 32'(dns[ch] - d0), 32'(exp_dn));
  endtask

  initial begin
    int u0, d0, v0, s0, ch_drop;
    logic [11:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      chval[i] = 12'h600; stores_seen[i] = 0; ups[i] = 0; dns[i] = 0;
    end
    do_reset();

    // neutral scan: channels alternate, no steps
    enable = 1'b1;
    s0 = n_starts;
    repeat (3 * 16 + 8) @(negedge clk);
    chk("neutral_starts", 32'(n_starts - s0), 32'd4);
    chk("neutral_steps", 32'(ups[0] + ups[1] + dns[0] + dns[1]), 32'd0);

    // hold and auto-repeat on ch0: pulses at store 1, 3, 4, 5, 6
    wait_stores(0, 1);
    chval[0] = 12'h800;
    u0 = ups[0]; d0 = dns[0];
    wait_stores(0, 6);
    chk("repeat_up_count", 32'(ups[0] - u0), 32'd5);
    chk("repeat_dn_count", 32'(dns[0] - d0), 32'd0);

    // threshold boundaries
    set_and_check(0, 12'h750, 0, 0, "b750");
    set_and_check(0, 12'h500, 0, 0, "b500");
    set_and_check(0, 12'h751, 1, 0, "b751");
    set_and_check(0, 12'h4FF, 0, 1, "b4ff");
    chval[0] = 12'h600;

    // direct reversal on ch1
    set_and_check(1, 12'h800, 1, 0, "rev_up");
    wait_stores(1, 0);
    chval[1] = 12'h100;
    u0 = ups[1]; d0 = dns[1];
    wait_stores(1, 1);
    chk("rev_dn_up", 32'(ups[1] - u0), 32'd0);
    chk("rev_dn_dn", 32'(dns[1] - d0), 32'd1);
    chval[1] = 12'h600;

    // enable dropped during WAIT
    wait_start();
    ch_drop = m_next_chan;
    v0 = n_valids;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("drop_valid", 32'(n_valids - v0), 32'd1);
    s0 = n_starts;
    repeat (60) @(negedge clk);
    chk("drop_idle_starts", 32'(n_starts - s0), 32'd0);
    enable = 1'b1;
    wait_start();
    chk("resume_chan", 32'(adc_chan), 32'((ch_drop + 1) % NUM_CH));

    // randomized values and enable toggling
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: v = 12'h750;
        1: v = 12'h500;
        2: v = 12'h751;
        3: v = 12'h4FF;
        default: v = 12'($urandom_range(0, 4095));
      endcase
      chval[$urandom_range(0, NUM_CH - 1)] = v;
      enable = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(5, 90)) @(negedge clk);
    end
    enable = 1'b1;
    repeat (40) @(negedge clk);

`ifdef JOY_ADC_TIMEOUT_EN
    // conversion timeout
    wait_stores(0, 1);
    respond_en = 1'b0;
    wait_start();
    repeat (TIMEOUT) @(negedge clk);
    chk("err_before_timeout", 32'(adc_err), 32'd0);
    @(negedge clk);
    chk("err_after_timeout", 32'(adc_err), 32'd1);
    m_next_chan = (m_next_chan + 1) % NUM_CH;
    wait_start();
    chk("err_sticky", 32'(adc_err), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("err_async_clear", 32'(adc_err), 32'd0);
    respond_en = 1'b1;
    do_reset();
    repeat (80) @(negedge clk);
`endif

    enable = 1'b0;
    repeat (60) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("adc_err_final", 32'(adc_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
